data_memory_ctrl: RTL and testbench
===================================

DATA_MEMORY_CTRL -- requirements
Module: data_memory_ctrl

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 16: data and address word width; multiple of 8.
REQ-002 The block SHALL have parameter ADDR_BITS, default 10: implemented depth is 2**ADDR_BITS words.
REQ-003 The block SHALL have parameter WRITE_FIRST, default 0: write-response data mode (0 = old word, 1 = merged new word).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is present.
REQ-007 The block SHALL have port req_ready, output, 1 bit: a request is accepted this cycle.
REQ-008 The block SHALL have port memaddr, input, WORD_SIZE bits: word address.
REQ-009 The block SHALL have port memval, input, WORD_SIZE bits: store data.
REQ-010 The block SHALL have port memget, input, 1 bit: read request.
REQ-011 The block SHALL have port memset, input, 1 bit: write request.
REQ-012 The block SHALL have port byte_en, input, WORD_SIZE/8 bits: per-byte write enable, bit i covering bits [8i+7:8i].
REQ-013 The block SHALL have port rsp_valid, output, 1 bit: response present.
REQ-014 The block SHALL have port rsp_ready, input, 1 bit: consumer takes the response.
REQ-015 The block SHALL have port memout, output, WORD_SIZE bits: response data.
REQ-016 The block SHALL have port rsp_err, output, 1 bit: the response is for an out-of-range address.
REQ-017 The block SHALL have port init_done, output, 1 bit: the clear sequence has finished.

Function
REQ-018 A transfer SHALL occur when req_valid && req_ready are both high on a rising clk edge; rsp_valid/rsp_ready SHALL handshake in the same way.
REQ-019 FSM states SHALL be CLEAR and RUN; reset enters CLEAR with the clear pointer at 0.
REQ-020 In CLEAR the block SHALL write zero to one address per cycle (0 to 2**ADDR_BITS-1) with req_ready=0, then enter RUN and set init_done=1 on the edge after the last write.
REQ-021 In RUN, req_ready SHALL equal !rsp_valid || rsp_ready, giving a one-entry response register with full throughput.
REQ-022 Range check: an address with any memaddr bit at or above ADDR_BITS set is out of range; the index SHALL be memaddr[ADDR_BITS-1:0].
REQ-023 An accepted read (memget=1, memset=0) SHALL present the stored word on memout with rsp_valid=1 on the next edge, giving 1-cycle latency.
REQ-024 An accepted write (memset=1) SHALL update only the bytes with byte_en set, and SHALL respond next edge with the old word when WRITE_FIRST=0 or the merged word when WRITE_FIRST=1.
REQ-025 If memget=1 and memset=1, the request SHALL be treated as a write per REQ-024.
REQ-026 An accepted request with memget=0 and memset=0 SHALL be consumed with no memory change and no response.
REQ-027 An out-of-range request SHALL leave memory unchanged and respond with memout=0, rsp_err=1; in-range responses SHALL have rsp_err=0.
REQ-028 While rsp_valid=1 and rsp_ready=0, memout, rsp_err and rsp_valid SHALL hold stable.
REQ-029 A read in the cycle after a write to the same address SHALL return the written (merged) data; there is no hazard window.
REQ-030 A write with byte_en all zero SHALL be accepted and responded to, and SHALL leave memory unchanged.

Reset
REQ-031 When rst_n=0, the block SHALL immediately set req_ready=0, rsp_valid=0, memout=0, rsp_err=0, init_done=0, clear pointer=0 and state=CLEAR.
REQ-032 A reset asserted mid-CLEAR or mid-RUN SHALL drop any pending response and restart the clear from address 0; memory contents after reset SHALL all be zero once init_done=1.

Verification (WORD_SIZE=16, ADDR_BITS=4)
REQ-033 Release reset and hold req_valid=0 -> init_done rises exactly 16 edges later and req_ready=1; then read addresses 0..15 -> every word is 0x0000, rsp_err=0.
REQ-034 Write 0xBEEF to address 5 with byte_en=11, then read address 5 the next cycle -> write response 0x0000 (WRITE_FIRST=0) or 0xBEEF (WRITE_FIRST=1); read response 0xBEEF.
REQ-035 Write 0x12AA to address 5 with byte_en=01 -> address 5 reads 0xBEAA.
REQ-036 Read address 0x0010 -> memout=0x0000, rsp_err=1; then write 0xFFFF to 0x0015 -> rsp_err=1 and address 5 is unchanged.
REQ-037 Back-to-back reads with rsp_ready=0 for 3 cycles -> req_ready=0 after the first acceptance, memout holds stable, no response is lost when rsp_ready returns to 1.
REQ-038 Pulse rst_n low at clear pointer 7 -> outputs reset immediately, and init_done rises 16 edges after release.

Source files
------------

// File: rtl/data_memory_ctrl.sv
// Word-addressed data memory with a valid/ready request port and a one-entry
// response register. After reset the whole array is zeroed one word per cycle
// before requests are accepted.
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | writing zero to mem[clr_ptr]; requests held off
// RUN   | serving reads/writes; req_ready follows response-register space
module data_memory_ctrl #(
   parameter int WORD_SIZE   = 16,
   parameter int ADDR_BITS   = 10,
   parameter int WRITE_FIRST = 0
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   req_valid,
   output logic                   req_ready,
   input  logic [WORD_SIZE-1:0]   memaddr,
   input  logic [WORD_SIZE-1:0]   memval,
   input  logic                   memget,
   input  logic                   memset,
   input  logic [WORD_SIZE/8-1:0] byte_en,
   output logic                   rsp_valid,
   input  logic                   rsp_ready,
   output logic [WORD_SIZE-1:0]   memout,
   output logic                   rsp_err,
   output logic                   init_done
);

   localparam int DEPTH  = 1 << ADDR_BITS;
   localparam int NBYTES = WORD_SIZE / 8;

   typedef enum logic [0:0] {CLEAR = 1'b0, RUN = 1'b1} state_t;

   state_t                 state, state_nxt;
   logic [ADDR_BITS-1:0]   clr_ptr;
   logic                   clr_we;
   logic [WORD_SIZE-1:0]   mem [DEPTH];

   logic                   req_fire;
   logic                   in_range;
   logic [ADDR_BITS-1:0]   idx;
   logic [WORD_SIZE-1:0]   old_word;
   logic [WORD_SIZE-1:0]   merged_word;
   logic [WORD_SIZE-1:0]   rsp_data;
   logic                   wr_en;
   logic                   rsp_load;

   // State register and clear pointer; reset restarts the clear from word 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= CLEAR;
         clr_ptr <= '0;
      end else begin
         state <= state_nxt;
         if (state == CLEAR) clr_ptr <= clr_ptr + 1'b1;
      end
   end

   // Leave CLEAR on the same edge that writes the last word.
   always_comb begin
      state_nxt = state;
      case (state)
         CLEAR:   if (clr_ptr == '1) state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = CLEAR;
      endcase
   end

   // FSM outputs: accept only in RUN when the response register has room.
   always_comb begin
      req_ready = 1'b0;
      init_done = 1'b0;
      clr_we    = 1'b0;
      case (state)
         CLEAR: clr_we = 1'b1;
         RUN: begin
            init_done = 1'b1;
            req_ready = !rsp_valid || rsp_ready;
         end
         default: clr_we = 1'b1;
      endcase
   end

   assign req_fire = req_valid && req_ready;
   assign in_range = (memaddr >> ADDR_BITS) == '0;
   assign idx      = memaddr[ADDR_BITS-1:0];
   assign old_word = mem[idx];

   // Byte-lane merge of store data over the current word.
   always_comb begin
      merged_word = old_word;
      for (int b = 0; b < NBYTES; b++) begin
         if (byte_en[b]) merged_word[8*b +: 8] = memval[8*b +: 8];
      end
   end

   assign wr_en    = req_fire && memset && in_range;
   assign rsp_load = req_fire && (memget || memset);

   // Out-of-range requests answer with zero data; a write may echo old or merged word.
   always_comb begin
      rsp_data = old_word;
      if (!in_range)                          rsp_data = '0;
      else if (memset && (WRITE_FIRST != 0))  rsp_data = merged_word;
   end

   // Memory array: clear sequence has priority, then accepted in-range writes.
   always_ff @(posedge clk) begin
      if (clr_we)     mem[clr_ptr] <= '0;
      else if (wr_en) mem[idx]     <= merged_word;
   end

   // One-entry response register; holds while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         memout    <= '0;
         rsp_err   <= 1'b0;
      end else if (rsp_load) begin
         rsp_valid <= 1'b1;
         memout    <= rsp_data;
         rsp_err   <= !in_range;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Directed bench for data_memory_ctrl at WORD_SIZE=16, ADDR_BITS=4.
module tb_data_memory_ctrl;

   localparam int WS = 16;
   localparam int AB = 4;
   localparam int WF = 0;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [WS-1:0] memaddr;
   logic [WS-1:0] memval;
   logic          memget;
   logic          memset;
   logic [1:0]    byte_en;
   logic          rsp_valid;
   logic          rsp_ready;
   logic [WS-1:0] memout;
   logic          rsp_err;
   logic          init_done;

   int checks   = 0;
   int failures = 0;
   int n_edges;

   always #5 clk = ~clk;

   data_memory_ctrl #(.WORD_SIZE(WS), .ADDR_BITS(AB), .WRITE_FIRST(WF)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .memaddr   (memaddr),
      .memval    (memval),
      .memget    (memget),
      .memset    (memset),
      .byte_en   (byte_en),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .memout    (memout),
      .rsp_err   (rsp_err),
      .init_done (init_done)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic g, input logic s,
                        input logic [WS-1:0] a, input logic [WS-1:0] d, input logic [1:0] be);
      req_valid = v;
      memget    = g;
      memset    = s;
      memaddr   = a;
      memval    = d;
      byte_en   = be;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      while (init_done !== 1'b1 && n < 64) begin
         tick();
         n++;
      end
   endtask

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
      tick();
      tick();
      chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_memout",    {16'd0, memout},    32'd0);
      chk("rst_rsp_err",   {31'd0, rsp_err},   32'd0);
      chk("rst_init_done", {31'd0, init_done}, 32'd0);

      rst_n = 1'b1;
      wait_init(n_edges);
      chk("init_edges", n_edges, 32'd16);
      chk("init_req_ready", {31'd0, req_ready}, 32'd1);

      // Back-to-back reads of the freshly cleared array.
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 1'b1, 1'b0, WS'(i), '0, 2'b11);
         tick();
         chk($sformatf("clr_read_%0d", i), {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b0, 16'h0000});
      end

      drive(1'b1, 1'b0, 1'b1, 16'd5, 16'hBEEF, 2'b11);
      tick();
      chk("wr_beef_rsp", {15'd0, rsp_valid, rsp_err, memout},
          {15'd0, 1'b1, 1'b0, (WF != 0) ? 16'hBEEF : 16'h0000});
      drive(1'b1, 1'b1, 1'b0, 16'd5, '0, 2'b00);
      tick();
      chk("raw_read5", {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b0, 16'hBEEF});

      drive(1'b1, 1'b0, 1'b1, 16'd5, 16'h12AA, 2'b01);
      tick();
      chk("wr_lo_rsp", {16'd0, memout}, {16'd0, (WF != 0) ? 16'hBEAA : 16'hBEEF});
      drive(1'b1, 1'b1, 1'b0, 16'd5, '0, 2'b00);
      tick();
      chk("read5_merged", {16'd0, memout}, 32'h0000_BEAA);

      drive(1'b1, 1'b1, 1'b0, 16'h0010, '0, 2'b00);
      tick();
      chk("oor_read", {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b1, 16'h0000});
      drive(1'b1, 1'b0, 1'b1, 16'h0015, 16'hFFFF, 2'b11);
      tick();
      chk("oor_write", {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b1, 16'h0000});
      drive(1'b1, 1'b1, 1'b0, 16'd5, '0, 2'b00);
      tick();
      chk("read5_after_oor", {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b0, 16'hBEAA});

      // Request with neither get nor set: consumed, no response.
      drive(1'b1, 1'b0, 1'b0, 16'd5, 16'h5555, 2'b11);
      tick();
      chk("noop_no_rsp", {31'd0, rsp_valid}, 32'd0);
      drive(1'b1, 1'b0, 1'b1, 16'd5, 16'h0000, 2'b00);
      tick();
      chk("be0_write_rsp", {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b0, 16'hBEAA});
      drive(1'b1, 1'b1, 1'b0, 16'd5, '0, 2'b00);
      tick();
      chk("read5_after_be0", {16'd0, memout}, 32'h0000_BEAA);
      drive(1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
      tick();
      chk("idle_rsp_drained", {31'd0, rsp_valid}, 32'd0);

      // Backpressure: first read held, second read waits.
      rsp_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 16'd5, '0, 2'b00);
      tick();
      chk("bp_first_rsp", {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b0, 16'hBEAA});
      drive(1'b1, 1'b1, 1'b0, 16'd3, '0, 2'b00);
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp_ready_low_%0d", c), {31'd0, req_ready}, 32'd0);
         tick();
         chk($sformatf("bp_hold_%0d", c), {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b0, 16'hBEAA});
      end
      rsp_ready = 1'b1;
      #1;
      chk("bp_ready_back", {31'd0, req_ready}, 32'd1);
      tick();
      chk("bp_second_rsp", {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b0, 16'h0000});
      drive(1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
      tick();
      chk("bp_drained", {31'd0, rsp_valid}, 32'd0);

      // Reset mid-RUN with a stalled response pending.
      rsp_ready = 1'b0;
      drive(1'b1, 1'b1, 1'b0, 16'd5, '0, 2'b00);
      tick();
      drive(1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
      chk("pending_before_rst", {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b0, 16'hBEAA});
      rst_n = 1'b0;
      #1;
      chk("run_rst_outputs", {13'd0, req_ready, rsp_valid, rsp_err, init_done, memout}, 32'd0);
      tick();
      rst_n     = 1'b1;
      rsp_ready = 1'b1;

      // Reset again once the clear pointer has reached 7.
      for (int c = 0; c < 7; c++) tick();
      chk("mid_clear_not_done", {31'd0, init_done}, 32'd0);
      rst_n = 1'b0;
      #1;
      chk("clear_rst_outputs", {13'd0, req_ready, rsp_valid, rsp_err, init_done, memout}, 32'd0);
      tick();
      rst_n = 1'b1;
      wait_init(n_edges);
      chk("reinit_edges", n_edges, 32'd16);
      chk("reinit_req_ready", {31'd0, req_ready}, 32'd1);

      drive(1'b1, 1'b1, 1'b0, 16'd5, '0, 2'b00);
      tick();
      chk("read5_after_reinit", {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b0, 16'h0000});
      drive(1'b1, 1'b1, 1'b0, 16'd15, '0, 2'b00);
      tick();
      chk("read15_after_reinit", {15'd0, rsp_valid, rsp_err, memout}, {15'd0, 1'b1, 1'b0, 16'h0000});
      drive(1'b0, 1'b0, 1'b0, '0, '0, 2'b00);
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
